// File: rtl/beep_tone_decoder_if.sv
// beep_tone_decoder_if
// Bundles the beep monitor signals so the decoder and its user share one port.
//   beep_in    : square-wave line being monitored (asynchronous to clk)
//   note       : decoded note code, 0 = silence / unknown
//   period     : last measured rising-edge to rising-edge period, in clk cycles
//   note_valid : one-cycle pulse whenever note changes value
//   active     : high while rising edges keep arriving within the timeout
// The master modport is the side that drives beep_in and observes the results.
// The slave modport is the decoder itself.
interface beep_tone_decoder_if;
   logic        beep_in;
   logic [3:0]  note;
   logic [19:0] period;
   logic        note_valid;
   logic        active;

   modport master (output beep_in, input note, period, note_valid, active);
   modport slave  (input beep_in, output note, period, note_valid, active);
endinterface

// File: rtl/beep_tone_decoder.sv
// beep_tone_decoder
// Measures the period of a square-wave beep line between rising edges and
// decodes it into a note code from the note table. A stability filter only
// lets the output note change after STABLE consecutive periods agree. If no
// rising edge arrives within TIMEOUT cycles, the line is declared silent.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : beep_tone_decoder_if.slave (beep_in in; note, period, note_valid, active out)
// P_TABLE holds the ten reference periods, with code 1 in the lowest 20 bits.
module beep_tone_decoder #(
   parameter int unsigned    TOL_SHIFT = 7,
   parameter int unsigned    STABLE    = 2,
   parameter logic [19:0]    TIMEOUT   = 20'hFFFFF,
   parameter logic [199:0]   P_TABLE   = {20'd170358, 20'd191205, 20'd202429, 20'd227273,
                                          20'd255102, 20'd270270, 20'd286533, 20'd303030,
                                          20'd340136, 20'd381679}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   beep_tone_decoder_if.slave        bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COUNT    = 2'd1;
   localparam logic [1:0] ST_CLASSIFY = 2'd2;
   localparam logic [2:0] STABLE_C    = 3'(STABLE);

   logic [1:0]  state_r;
   logic        s1_r, s2_r, s3_r;
   logic [19:0] pcnt_r;
   logic [19:0] period_r;
   logic [3:0]  note_r;
   logic [3:0]  cand_r;
   logic [2:0]  run_r;
   logic        note_valid_r;
   logic        active_r;

   logic        rise_s;
   logic [9:0]  match_s;
   logic [3:0]  code_s;
   logic [3:0]  cand_nxt_s;
   logic [2:0]  run_nxt_s;

   // True when meas lies within +/- (p_ref >> TOL_SHIFT) of p_ref.
   // The 21-bit subtract keeps the sign so the magnitude can be recovered.
   function automatic logic period_match(input logic [19:0] meas, input logic [19:0] p_ref);
      logic [20:0] diff;
      logic [20:0] mag;
      logic [19:0] tol;
      diff = {1'b0, meas} - {1'b0, p_ref};
      mag  = diff[20] ? (21'd0 - diff) : diff;
      tol  = p_ref >> TOL_SHIFT;
      return (mag <= {1'b0, tol});
   endfunction

   assign rise_s = s2_r & ~s3_r;

   // Two-stage synchronizer for beep_in plus a history stage for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= bus.beep_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Compares the captured period against every table entry; the lowest code wins.
   always_comb begin
      match_s = 10'd0;
      code_s  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         match_s[i] = period_match(period_r, P_TABLE[i*20 +: 20]);
      end
      for (int i = 9; i >= 0; i--) begin
         code_s = match_s[i] ? 4'(i + 1) : code_s;
      end
   end

   // Next candidate and run length of the stability filter.
   always_comb begin
      cand_nxt_s = cand_r;
      run_nxt_s  = run_r;
      if (code_s == cand_r) begin
         run_nxt_s = (run_r >= STABLE_C) ? STABLE_C : (run_r + 3'd1);
      end else begin
         cand_nxt_s = code_s;
         run_nxt_s  = 3'd1;
      end
   end

   // Period measurement state machine, stability filter and silence handling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         pcnt_r       <= 20'd0;
         period_r     <= 20'd0;
         note_r       <= 4'd0;
         cand_r       <= 4'd0;
         run_r        <= 3'd0;
         note_valid_r <= 1'b0;
         active_r     <= 1'b0;
      end else begin
         note_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // The first edge only provides a reference point.
               if (rise_s) begin
                  pcnt_r  <= 20'd1;
                  state_r <= ST_COUNT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               // An edge on the timeout cycle is still a valid measurement.
               if (rise_s) begin
                  period_r <= pcnt_r;
                  pcnt_r   <= 20'd1;
                  active_r <= 1'b1;
                  state_r  <= ST_CLASSIFY;
               end else if (pcnt_r == TIMEOUT) begin
                  state_r  <= ST_IDLE;
                  active_r <= 1'b0;
                  cand_r   <= 4'd0;
                  run_r    <= 3'd0;
                  if (note_r != 4'd0) begin
                     note_r       <= 4'd0;
                     note_valid_r <= 1'b1;
                  end else begin
                     note_r       <= note_r;
                  end
               end else begin
                  pcnt_r <= pcnt_r + 20'd1;
               end
            end
            ST_CLASSIFY: begin
               // The next period is already being counted during this cycle.
               pcnt_r  <= (pcnt_r == TIMEOUT) ? pcnt_r : (pcnt_r + 20'd1);
               cand_r  <= cand_nxt_s;
               run_r   <= run_nxt_s;
               state_r <= ST_COUNT;
               if ((run_nxt_s == STABLE_C) && (cand_nxt_s != note_r)) begin
                  note_r       <= cand_nxt_s;
                  note_valid_r <= 1'b1;
               end else begin
                  note_r       <= note_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.note       = note_r;
   assign bus.period     = period_r;
   assign bus.note_valid = note_valid_r;
   assign bus.active     = active_r;

endmodule

// File: tb/tb_beep_tone_decoder.sv
// tb_beep_tone_decoder
// Drives square waves of chosen periods into beep_tone_decoder. A reference
// model computes, at each driven rising edge, whether and when the note must
// change; those events go into a scoreboard queue that a monitor compares
// against note_valid / note / period cycle by cycle. The note table is scaled
// down (about 1/256) and the timeout shortened so the run stays short.
module tb_beep_tone_decoder;

   localparam int TOL_SHIFT_TB = 7;
   localparam int STABLE_TB    = 2;
   localparam int TIMEOUT_TB   = 2000;
   localparam int TBL [10]     = '{1491, 1329, 1184, 1119, 1056, 996, 888, 791, 747, 665};
   localparam logic [199:0] P_TBL = {20'd665, 20'd747, 20'd791, 20'd888, 20'd996,
                                     20'd1056, 20'd1119, 20'd1184, 20'd1329, 20'd1491};

   typedef struct {
      logic [3:0]  note;
      logic [19:0] period;
      int          at;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   // reference model state
   logic        m_armed;
   logic        m_active;
   logic [3:0]  m_note;
   logic [3:0]  m_cand;
   int          m_run;
   logic [19:0] m_period;
   int          m_last;

   beep_tone_decoder_if bus ();

   beep_tone_decoder #(
      .TOL_SHIFT (TOL_SHIFT_TB),
      .STABLE    (STABLE_TB),
      .TIMEOUT   (20'd2000),
      .P_TABLE   (P_TBL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] ref_code(input int p);
      int d;
      for (int i = 0; i < 10; i++) begin
         d = (p > TBL[i]) ? (p - TBL[i]) : (TBL[i] - p);
         if (d <= (TBL[i] >> TOL_SHIFT_TB)) return 4'(i + 1);
      end
      return 4'd0;
   endfunction

   task automatic model_reset();
      m_armed  = 1'b0;
      m_active = 1'b0;
      m_note   = 4'd0;
      m_cand   = 4'd0;
      m_run    = 0;
      m_period = 20'd0;
      m_last   = 0;
   endtask

   // Called at the negedge where a rising edge is driven (cycle n);
   // a note change becomes visible at the negedge of cycle n+4.
   task automatic model_rise();
      logic [3:0] code;
      if (m_armed) begin
         m_period = 20'(cyc - m_last);
         m_active = 1'b1;
         code = ref_code(cyc - m_last);
         if (code == m_cand) begin
            m_run = (m_run >= STABLE_TB) ? STABLE_TB : m_run + 1;
         end else begin
            m_cand = code;
            m_run  = 1;
         end
         if (m_run == STABLE_TB && m_cand != m_note) begin
            m_note = m_cand;
            sb.push_back('{m_note, m_period, cyc + 4});
         end
      end else begin
         m_armed = 1'b1;
      end
      m_last = cyc;
   endtask

   // One full square-wave period of n cycles, starting with a rising edge.
   task automatic drive_period(input int n);
      @(negedge clk);
      bus.beep_in = 1'b1;
      model_rise();
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         if (i == n / 2) bus.beep_in = 1'b0;
         if (i == 5) begin
            check_eq("period", 32'(bus.period), 32'(m_period));
            check_eq("active", 32'(bus.active), 32'(m_active));
         end
      end
   endtask

   // Stop toggling; the decoder must time out TIMEOUT cycles after the last capture.
   task automatic go_silent();
      if (m_note != 4'd0) sb.push_back('{4'd0, m_period, m_last + 3 + TIMEOUT_TB});
      m_note   = 4'd0;
      m_cand   = 4'd0;
      m_run    = 0;
      m_armed  = 1'b0;
      m_active = 1'b0;
      bus.beep_in = 1'b0;
      repeat (TIMEOUT_TB + 10) @(negedge clk);
      check_eq("silent_active", 32'(bus.active), 32'(m_active));
      check_eq("silent_period", 32'(bus.period), 32'(m_period));
   endtask

   // Scoreboard monitor: note_valid must pulse exactly at the predicted cycles.
   initial begin
      exp_t       e;
      logic       exp_valid;
      logic [3:0] mon_note;
      mon_note = 4'd0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            exp_valid = (sb.size() != 0) && (sb[0].at == cyc);
            check_eq("note_valid", 32'(bus.note_valid), 32'(exp_valid));
            if (exp_valid) begin
               e = sb.pop_front();
               mon_note = e.note;
               check_eq("note_period", 32'(bus.period), 32'(e.period));
            end
            check_eq("note", 32'(bus.note), 32'(mon_note));
         end else begin
            mon_note = 4'd0;
         end
      end
   end

   initial begin
      model_reset();
      rst_n       = 1'b0;
      bus.beep_in = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("rst_note", 32'(bus.note), 32'd0);
      check_eq("rst_period", 32'(bus.period), 32'd0);
      check_eq("rst_note_valid", 32'(bus.note_valid), 32'd0);
      check_eq("rst_active", 32'(bus.active), 32'd0);
      rst_n = 1'b1;

      // A4 from reset: note appears after the third edge
      repeat (4) drive_period(888);
      // tolerance edge: +6 still matches A4, +7 does not
      repeat (3) drive_period(894);
      repeat (3) drive_period(895);
      // back to A4, then switch to C4
      repeat (3) drive_period(888);
      repeat (3) drive_period(1491);
      // silence, then restart at B4
      go_silent();
      repeat (4) drive_period(791);
      // G4 with a single short glitch period
      repeat (3) drive_period(996);
      drive_period(200);
      repeat (3) drive_period(996);
      // edge landing exactly on the timeout count
      drive_period(TIMEOUT_TB);
      repeat (3) drive_period(996);
      // very short periods classify as unknown
      repeat (2) drive_period(3);
      repeat (3) drive_period(996);

      // reset in the middle of a period
      @(negedge clk);
      bus.beep_in = 1'b1;
      model_rise();
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_note", 32'(bus.note), 32'd0);
      check_eq("mid_rst_period", 32'(bus.period), 32'd0);
      check_eq("mid_rst_active", 32'(bus.active), 32'd0);
      model_reset();
      repeat (3) @(negedge clk);
      bus.beep_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) drive_period(888);

      repeat (10) @(negedge clk);
      check_eq("pending_events", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/beep_tone_decoder.md
# beep_tone_decoder

Receive-side counterpart to the buzzer tone generators: samples a square-wave `beep` line, measures its period in clock cycles and decodes it into a note code from the game's note table. It sits on the monitor/loopback path so game logic and the self-test bench can confirm which note the buzzer is playing, and detect silence.

## Interface

Parameters:
- `TOL_SHIFT`, 7: match tolerance is `P[i] >> TOL_SHIFT` cycles, about ±0.78 %.
- `STABLE`, 2: number of consecutive periods with the same code required before `note` changes (range 1..7).
- `TIMEOUT`, 20'hFFFFF: cycles without a rising edge before the input is declared silent.

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `beep_in`, in, 1: asynchronous square-wave input.
- `note`, out, 4: decoded note code. 0 means silence or unknown.
- `period`, out, 20: last measured period in clk cycles.
- `note_valid`, out, 1: one-cycle pulse when `note` changes value.
- `active`, out, 1: high while edges arrive within `TIMEOUT`.

## Operation

Note table, as code and period in cycles:
- 1 C4 381679, 2 D4 340136, 3 E4 303030, 4 F4 286533, 5 FS4 270270
- 6 G4 255102, 7 A4 227273, 8 B4 202429, 9 C5 191205, 10 D5 170358
- Codes 11..15 are never output.

Input path:
- `beep_in` passes through a 2-FF synchronizer (`s1`, `s2`) plus a history FF `s3`.
- `rise = s2 & ~s3`. Only rising edges are measured; the duty cycle is ignored.

States:
- IDLE: no reference edge held. On `rise`, load `pcnt` with 1 and go to COUNT.
- COUNT: `pcnt` increments by 1 per cycle and saturates at `TIMEOUT`.
  - On `rise`: capture `period <= pcnt`, reload `pcnt` with 1, set `active` = 1, go to CLASSIFY.
  - If `pcnt == TIMEOUT`: go to IDLE, clear `active`, force silence (see below).
- CLASSIFY: one cycle.
  - All ten table entries are compared in parallel. Entry i matches when `|period - P[i]| <= P[i] >> TOL_SHIFT`.
  - Code = lowest matching i, or 0 if none match.
  - `pcnt` keeps counting during this cycle. Return to COUNT.

Stability filter:
- Holds candidate `cand` (4 b) and run counter `run` (3 b).
- If code == `cand`, `run` increments, saturating at `STABLE`. Otherwise `cand` <= code and `run` <= 1.
- When `run` reaches `STABLE` (after the update) and `cand != note`: `note <= cand`, `note_valid` pulses.

Silence (timeout):
- If `note != 0`: `note <= 0` and `note_valid` pulses in the same cycle.
- Always: `cand <= 0`, `run <= 0`. `period` holds its last value.

Arithmetic:
- All arithmetic is unsigned 20-bit. The absolute difference uses a 21-bit subtract.
- Periods of 1 or 2 cycles are legal: they classify as 0 and raise no error.

## Timing

Reset values (asynchronous, on `rst_n` = 0, any state):
- State IDLE; `note` = 0, `period` = 0, `note_valid` = 0, `active` = 0.
- `pcnt` = 0, `cand` = 0, `run` = 0, `s1`/`s2`/`s3` = 0.
- A reset mid-period discards the partial measurement. The first edge after reset only arms the block.

Latency:
- `beep_in` is sampled high at clk edge k.
- `rise` is valid during cycle k+1 to k+2.
- `period` updates at edge k+2; classification registers at k+3.
- `note`/`note_valid` update at edge k+3. Total: 3 cycles from sample to output.

Boundary conditions:
- The first `note` change needs `STABLE` + 1 rising edges.
- `rise` coinciding with `pcnt == TIMEOUT`: the edge wins. The period is captured as `TIMEOUT`, classifies as 0, and no timeout action occurs.
- `rise` arriving during CLASSIFY: impossible, since the minimum spacing between rises is 2 cycles, so no handling is needed.
- Code changes back to the current `note` value: no `note_valid`.
- `note_valid` is never high for two consecutive cycles.

## Test plan

- Reset with `rst_n` low for 5 cycles: all outputs 0. Release, then drive 440 Hz (period 227273): after the 3rd rising edge plus 3 cycles, `note` = 7, one `note_valid` pulse, `period` = 227273, `active` = 1.
- Tolerance: period 227273 + 1775 gives `note` 7; period 227273 + 1776 gives code 0, so `note` goes to 0 after 2 such periods.
- Switch from 440 Hz to 262 Hz (381679): one off-table-free transition, `note` goes 7 → 1 after 2 new periods, exactly one `note_valid`.
- Silence: stop toggling mid-note. Exactly 1048575 − `pcnt` cycles later, `note` = 0, `note_valid` pulses once, `active` = 0. Restarting at 494 Hz gives `note` = 8 after 3 edges.
- Glitch: insert a single 50 000-cycle period inside a steady 392 Hz stream. `note` stays 6 with no `note_valid` (STABLE = 2).
- Assert `rst_n` low mid-period, then release: outputs are 0 immediately, and the first post-reset edge produces no `period` update.
